// File: rtl/mem_stage_access.sv
// mem_stage_access: MEM-stage data-memory sequencer for LDR/STR, LDB/STB and LDI/STI.
// Ports: clk, reset (sync, active-high); EX/MEM inputs valid_in, mem_read_in, mem_write_in,
// byte_in, indirect_in, addr_in, wdata_in; memory side dmem_rdata/dmem_resp in and
// dmem_read/dmem_write/dmem_address/dmem_wdata/dmem_byte_enable out; mem_result,
// result_valid and stall back to the pipeline.
module mem_stage_access #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic                  byte_in,
  input  logic                  indirect_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] wdata_in,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  input  logic                  dmem_resp,
  output logic                  dmem_read,
  output logic                  dmem_write,
  output logic [ADDR_WIDTH-1:0] dmem_address,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic [1:0]            dmem_byte_enable,
  output logic [DATA_WIDTH-1:0] mem_result,
  output logic                  result_valid,
  output logic                  stall
);
  typedef enum logic [1:0] {IDLE, IND, ACC, DONE} state_t;
  state_t state;
  logic [ADDR_WIDTH-1:0] ptr, ea;
  logic [7:0] rbyte;
  logic req;
  assign req = valid_in & (mem_read_in | mem_write_in);
  assign stall = req & (state != DONE);
  assign result_valid = state == DONE;
  assign ea = indirect_in ? ptr : addr_in;
  assign rbyte = ea[0] ? dmem_rdata[15:8] : dmem_rdata[7:0];
  always_comb begin
    dmem_read = (state == IND) | ((state == ACC) & mem_read_in);
    dmem_write = (state == ACC) & mem_write_in & ~mem_read_in;
    dmem_address = state == IND ? {addr_in[ADDR_WIDTH-1:1], 1'b0} :
                   state == ACC ? (byte_in ? ea : {ea[ADDR_WIDTH-1:1], 1'b0}) : '0;
    dmem_byte_enable = state != ACC ? 2'b00 : !byte_in ? 2'b11 : ea[0] ? 2'b10 : 2'b01;
    dmem_wdata = state != ACC ? '0 : byte_in ? {(DATA_WIDTH/8){wdata_in[7:0]}} : wdata_in;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      mem_result <= '0;
    end else begin
      case (state)
        IDLE: if (req) state <= indirect_in ? IND : ACC;
        IND: if (dmem_resp) begin
          ptr <= dmem_rdata[ADDR_WIDTH-1:0];
          state <= ACC;
        end
        ACC: if (dmem_resp) begin
          mem_result <= !mem_read_in ? '0 : byte_in ? {{(DATA_WIDTH-8){1'b0}}, rbyte} : dmem_rdata;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
